// File: rtl/riscv_pkg.sv
// Shared RV32I pipeline constants: datapath widths, control-bundle bit
// positions and the operand-forwarding select encodings.
package riscv_pkg;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned RIDX_W = 5;
  localparam int unsigned CTRL_W = 12;

  // Bit positions inside the opaque control bundle
  localparam int unsigned CTRL_REGWE = 2;
  localparam int unsigned CTRL_MEMRD = 3;

  // Operand source selected by the forwarding comparators
  typedef enum logic [1:0] {
    FWD_REG = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

endpackage : riscv_pkg

// File: rtl/forward_select.sv
// Priority comparator choosing the source of one EX operand.
// Ports:
//   src_i              stored source register index of the operand
//   mem_rd_i/mem_we_i  MEM-stage destination index / write enable
//   wb_rd_i/wb_we_i    WB-stage destination index / write enable
//   sel_c_o            combinational select (FWD_MEM > FWD_WB > FWD_REG)
module forward_select #(
  parameter int unsigned RIDX_W = riscv_pkg::RIDX_W
) (
  input  logic [RIDX_W-1:0] src_i,
  input  logic [RIDX_W-1:0] mem_rd_i,
  input  logic              mem_we_i,
  input  logic [RIDX_W-1:0] wb_rd_i,
  input  logic              wb_we_i,
  output logic [1:0]        sel_c_o
);
  import riscv_pkg::*;

  // The younger MEM result wins over WB; x0 is never forwarded
  always_comb begin
    sel_c_o = FWD_REG;
    if (mem_we_i && (mem_rd_i != '0) && (mem_rd_i == src_i)) begin
      sel_c_o = FWD_MEM;
    end else if (wb_we_i && (wb_rd_i != '0) && (wb_rd_i == src_i)) begin
      sel_c_o = FWD_WB;
    end
  end

endmodule : forward_select

// File: rtl/decode_execute_stage.sv
// ID/EX pipeline register of the RV32I core with load-use stall detection,
// bubble insertion on stall/flush, MEM/WB operand forwarding and a bubble
// performance counter.
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   id_*                        decode-stage instruction fields
//   flush                       taken branch/jump resolved in EX
//   mem_rd/mem_we/mem_result    MEM-stage writeback info for forwarding
//   wb_rd/wb_we/wb_result       WB-stage writeback info for forwarding
//   stall                       combinational load-use freeze of PC and IF/ID
//   ex_*                        registered EX-stage fields, forwarded operands
//   bubble_cnt                  number of stall/flush bubbles inserted
module decode_execute_stage #(
  parameter int unsigned XLEN   = riscv_pkg::XLEN,
  parameter int unsigned RIDX_W = riscv_pkg::RIDX_W,
  parameter int unsigned CTRL_W = riscv_pkg::CTRL_W,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [RIDX_W-1:0] id_rs1,
  input  logic [RIDX_W-1:0] id_rs2,
  input  logic [RIDX_W-1:0] id_rd,
  input  logic [XLEN-1:0]   id_rd1,
  input  logic [XLEN-1:0]   id_rd2,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              flush,
  input  logic [RIDX_W-1:0] mem_rd,
  input  logic              mem_we,
  input  logic [XLEN-1:0]   mem_result,
  input  logic [RIDX_W-1:0] wb_rd,
  input  logic              wb_we,
  input  logic [XLEN-1:0]   wb_result,
  output logic              stall,
  output logic              ex_valid,
  output logic [RIDX_W-1:0] ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [XLEN-1:0]   ex_op_a,
  output logic [XLEN-1:0]   ex_op_b,
  output logic [XLEN-1:0]   ex_imm,
  output logic [XLEN-1:0]   ex_pc,
  output logic [CNT_W-1:0]  bubble_cnt
);
  import riscv_pkg::*;

  logic              ex_valid_q, ex_valid_d;
  logic [RIDX_W-1:0] ex_rd_q,    ex_rd_d;
  logic [RIDX_W-1:0] ex_rs1_q,   ex_rs1_d;
  logic [RIDX_W-1:0] ex_rs2_q,   ex_rs2_d;
  logic [CTRL_W-1:0] ex_ctrl_q,  ex_ctrl_d;
  logic [XLEN-1:0]   ex_rd1_q,   ex_rd1_d;
  logic [XLEN-1:0]   ex_rd2_q,   ex_rd2_d;
  logic [XLEN-1:0]   ex_imm_q,   ex_imm_d;
  logic [XLEN-1:0]   ex_pc_q,    ex_pc_d;
  logic [CNT_W-1:0]  cnt_q,      cnt_d;
  logic [1:0]        sel_a, sel_b;

  // Load in EX whose destination is read by the instruction in ID
  assign stall = id_valid & ex_valid_q & ex_ctrl_q[CTRL_MEMRD] &
                 (ex_rd_q != '0) &
                 ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));

  // Next EX contents: bubble on flush/stall, otherwise the ID instruction
  always_comb begin
    ex_valid_d = 1'b0;
    ex_ctrl_d  = '0;
    ex_rd_d    = '0;
    ex_rs1_d   = ex_rs1_q;
    ex_rs2_d   = ex_rs2_q;
    ex_rd1_d   = ex_rd1_q;
    ex_rd2_d   = ex_rd2_q;
    ex_imm_d   = ex_imm_q;
    ex_pc_d    = ex_pc_q;
    cnt_d      = cnt_q;
    if (flush || stall) begin
      // flush and stall together still insert only one bubble
      cnt_d = cnt_q + CNT_W'(1);
    end else begin
      ex_valid_d = id_valid;
      ex_ctrl_d  = id_valid ? id_ctrl : '0;
      ex_rd_d    = id_rd;
      ex_rs1_d   = id_rs1;
      ex_rs2_d   = id_rs2;
      ex_rd1_d   = id_rd1;
      ex_rd2_d   = id_rd2;
      ex_imm_d   = id_imm;
      ex_pc_d    = id_pc;
    end
  end

  // ID/EX state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid_q <= 1'b0;
      ex_ctrl_q  <= '0;
      ex_rd_q    <= '0;
      ex_rs1_q   <= '0;
      ex_rs2_q   <= '0;
      ex_rd1_q   <= '0;
      ex_rd2_q   <= '0;
      ex_imm_q   <= '0;
      ex_pc_q    <= '0;
      cnt_q      <= '0;
    end else begin
      ex_valid_q <= ex_valid_d;
      ex_ctrl_q  <= ex_ctrl_d;
      ex_rd_q    <= ex_rd_d;
      ex_rs1_q   <= ex_rs1_d;
      ex_rs2_q   <= ex_rs2_d;
      ex_rd1_q   <= ex_rd1_d;
      ex_rd2_q   <= ex_rd2_d;
      ex_imm_q   <= ex_imm_d;
      ex_pc_q    <= ex_pc_d;
      cnt_q      <= cnt_d;
    end
  end

  forward_select #(.RIDX_W(RIDX_W)) u_fwd_a (
    .src_i    (ex_rs1_q),
    .mem_rd_i (mem_rd),
    .mem_we_i (mem_we),
    .wb_rd_i  (wb_rd),
    .wb_we_i  (wb_we),
    .sel_c_o  (sel_a)
  );

  forward_select #(.RIDX_W(RIDX_W)) u_fwd_b (
    .src_i    (ex_rs2_q),
    .mem_rd_i (mem_rd),
    .mem_we_i (mem_we),
    .wb_rd_i  (wb_rd),
    .wb_we_i  (wb_we),
    .sel_c_o  (sel_b)
  );

  // Operand muxes driven by the forwarding selects
  always_comb begin
    ex_op_a = ex_rd1_q;
    ex_op_b = ex_rd2_q;
    case (sel_a)
      FWD_MEM: ex_op_a = mem_result;
      FWD_WB:  ex_op_a = wb_result;
      default: ex_op_a = ex_rd1_q;
    endcase
    case (sel_b)
      FWD_MEM: ex_op_b = mem_result;
      FWD_WB:  ex_op_b = wb_result;
      default: ex_op_b = ex_rd2_q;
    endcase
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rd      = ex_rd_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign ex_imm     = ex_imm_q;
  assign ex_pc      = ex_pc_q;
  assign bubble_cnt = cnt_q;

endmodule : decode_execute_stage

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage. Each cycle the stimulus drives
// the ID/forwarding inputs and pushes the expected view of that cycle
// (stall for the current ID instruction, EX contents from the previous edge,
// forwarded operands with the current MEM/WB inputs); the monitor pops and
// compares in the same cycle, away from the clock edges.
module tb_decode_execute_stage;

  localparam int unsigned TB_CNT_W = 4;
  localparam logic [11:0] C_ALU    = 12'h014;
  localparam logic [11:0] C_LOAD   = 12'h00C;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rd1, id_rd2, id_imm, id_pc;
  logic [11:0] id_ctrl;
  logic        flush;
  logic [4:0]  mem_rd, wb_rd;
  logic        mem_we, wb_we;
  logic [31:0] mem_result, wb_result;
  logic        stall, ex_valid;
  logic [4:0]  ex_rd;
  logic [11:0] ex_ctrl;
  logic [31:0] ex_op_a, ex_op_b, ex_imm, ex_pc;
  logic [TB_CNT_W-1:0] bubble_cnt;

  typedef struct {
    logic        stall;
    logic        valid;
    logic        full;
    logic [4:0]  rd;
    logic [11:0] ctrl;
    logic [31:0] opa;
    logic [31:0] opb;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  decode_execute_stage #(.CNT_W(TB_CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_valid   (id_valid),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_rd      (id_rd),
    .id_rd1     (id_rd1),
    .id_rd2     (id_rd2),
    .id_imm     (id_imm),
    .id_pc      (id_pc),
    .id_ctrl    (id_ctrl),
    .flush      (flush),
    .mem_rd     (mem_rd),
    .mem_we     (mem_we),
    .mem_result (mem_result),
    .wb_rd      (wb_rd),
    .wb_we      (wb_we),
    .wb_result  (wb_result),
    .stall      (stall),
    .ex_valid   (ex_valid),
    .ex_rd      (ex_rd),
    .ex_ctrl    (ex_ctrl),
    .ex_op_a    (ex_op_a),
    .ex_op_b    (ex_op_b),
    .ex_imm     (ex_imm),
    .ex_pc      (ex_pc),
    .bubble_cnt (bubble_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_tests++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  // Monitor: compares the DUT view against the expected entry of this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("stall",      32'(stall),      32'(e.stall));
        chk("ex_valid",   32'(ex_valid),   32'(e.valid));
        chk("ex_ctrl",    32'(ex_ctrl),    32'(e.ctrl));
        chk("bubble_cnt", 32'(bubble_cnt), 32'(e.cnt));
        if (e.full) begin
          chk("ex_rd",   32'(ex_rd), 32'(e.rd));
          chk("ex_op_a", ex_op_a,    e.opa);
          chk("ex_op_b", ex_op_b,    e.opb);
          chk("ex_imm",  ex_imm,     e.imm);
          chk("ex_pc",   ex_pc,      e.pc);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic id_set(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] rd1, input logic [31:0] rd2,
                        input logic [31:0] imm, input logic [31:0] pc, input logic [11:0] ctrl);
    id_valid = v;   id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
    id_rd1   = rd1; id_rd2 = rd2; id_imm = imm; id_pc = pc; id_ctrl = ctrl;
  endtask

  task automatic fw_set(input logic mwe, input logic [4:0] mrd, input logic [31:0] mres,
                        input logic wwe, input logic [4:0] wrd, input logic [31:0] wres);
    mem_we = mwe; mem_rd = mrd; mem_result = mres;
    wb_we  = wwe; wb_rd  = wrd; wb_result  = wres;
  endtask

  task automatic push(input logic st, input logic v, input logic full, input logic [4:0] rd,
                      input logic [11:0] ctrl, input logic [31:0] opa, input logic [31:0] opb,
                      input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] cnt);
    exp_t e;
    e.stall = st; e.valid = v; e.full = full; e.rd = rd; e.ctrl = ctrl;
    e.opa = opa; e.opb = opb; e.imm = imm; e.pc = pc; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    id_set(1'b1, 5'd1, 5'd2, 5'd3, 32'd11, 32'd22, 32'd100, 32'h40, C_ALU);
    fw_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);

    // Reset held two cycles with a valid instruction in ID
    step();
    step();
    push(1'b0, 1'b0, 1'b1, 5'd0, 12'h0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);

    // Release: view still shows the reset state, add x3,x1,x2 captured at this edge
    step(); rst_n = 1'b1;
    push(1'b0, 1'b0, 1'b1, 5'd0, 12'h0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);

    // lw x5 in ID; add now in EX
    step();
    id_set(1'b1, 5'd1, 5'd7, 5'd5, 32'h1000, 32'h77, 32'd4, 32'h44, C_LOAD);
    push(1'b0, 1'b1, 1'b1, 5'd3, C_ALU, 32'd11, 32'd22, 32'd100, 32'h40, 4'd0);

    // add x6,x5,x1 in ID with the load in EX -> load-use stall
    step();
    id_set(1'b1, 5'd5, 5'd1, 5'd6, 32'h55, 32'h11, 32'd0, 32'h48, C_ALU);
    push(1'b1, 1'b1, 1'b1, 5'd5, C_LOAD, 32'h1000, 32'h77, 32'd4, 32'h44, 4'd0);

    // Bubble in EX, add held in ID, load now in MEM
    step();
    fw_set(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'd0);
    push(1'b0, 1'b0, 1'b0, 5'd0, 12'h0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd1);

    // add in EX with rs1 forwarded from MEM
    step();
    id_set(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 12'h0);
    push(1'b0, 1'b1, 1'b1, 5'd6, C_ALU, 32'hDEAD_BEEF, 32'h11, 32'd0, 32'h48, 4'd1);

    // Forward-priority instruction (rs1=9, rd1=4) issued; invalid slot in EX
    step();
    fw_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    id_set(1'b1, 5'd9, 5'd0, 5'd10, 32'd4, 32'd0, 32'd8, 32'h50, C_ALU);
    push(1'b0, 1'b0, 1'b0, 5'd0, 12'h0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd1);

    // MEM and WB both hit x9 -> MEM wins
    step();
    fw_set(1'b1, 5'd9, 32'd7, 1'b1, 5'd9, 32'd3);
    push(1'b0, 1'b1, 1'b1, 5'd10, C_ALU, 32'd7, 32'd0, 32'd8, 32'h50, 4'd1);

    // Only WB hits -> WB value
    step();
    fw_set(1'b0, 5'd9, 32'd7, 1'b1, 5'd9, 32'd3);
    push(1'b0, 1'b1, 1'b1, 5'd10, C_ALU, 32'd3, 32'd0, 32'd8, 32'h50, 4'd1);

    // No forwarding -> stored rd1; load to x0 issued in ID
    step();
    fw_set(1'b0, 5'd9, 32'd7, 1'b0, 5'd9, 32'd3);
    id_set(1'b1, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'h60, C_LOAD);
    push(1'b0, 1'b1, 1'b1, 5'd10, C_ALU, 32'd4, 32'd0, 32'd8, 32'h50, 4'd1);

    // Load to x0 in EX, use of x0 in ID: no stall, MEM x0 write never forwarded
    step();
    fw_set(1'b1, 5'd0, 32'd99, 1'b0, 5'd0, 32'd0);
    id_set(1'b1, 5'd0, 5'd0, 5'd11, 32'd0, 32'd0, 32'd0, 32'h64, C_ALU);
    push(1'b0, 1'b1, 1'b1, 5'd0, C_LOAD, 32'd0, 32'd0, 32'd0, 32'h60, 4'd1);

    // lw x7 issued
    step();
    fw_set(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    id_set(1'b1, 5'd2, 5'd3, 5'd7, 32'h200, 32'h300, 32'd12, 32'h68, C_LOAD);
    push(1'b0, 1'b1, 1'b1, 5'd11, C_ALU, 32'd0, 32'd0, 32'd0, 32'h64, 4'd1);

    // Flush together with a load-use hazard on rs2 -> single bubble
    step();
    flush = 1'b1;
    id_set(1'b1, 5'd8, 5'd7, 5'd9, 32'd1, 32'd2, 32'd0, 32'h6C, C_ALU);
    push(1'b1, 1'b1, 1'b1, 5'd7, C_LOAD, 32'h200, 32'h300, 32'd12, 32'h68, 4'd1);

    // Plain flush of a valid instruction
    step();
    id_set(1'b1, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd1, 32'h70, C_ALU);
    push(1'b0, 1'b0, 1'b0, 5'd0, 12'h0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd2);

    step();
    flush = 1'b0;
    id_set(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 12'h0);
    push(1'b0, 1'b0, 1'b0, 5'd0, 12'h0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd3);

    // Run flush bubbles until the 4-bit counter wraps to 0
    for (int i = 1; i <= 13; i++) begin
      step();
      flush = 1'b1;
      id_set(1'b1, 5'd1, 5'd2, 5'd3, 32'd1, 32'd2, 32'd3, 32'h80 + 32'(i * 4), C_ALU);
      push(1'b0, 1'b0, 1'b0, 5'd0, 12'h0, 32'd0, 32'd0, 32'd0, 32'd0, 4'(3 + i - 1));
    end

    step();
    flush = 1'b0;
    id_set(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 12'h0);
    push(1'b0, 1'b0, 1'b0, 5'd0, 12'h0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);

    step();
    push(1'b0, 1'b0, 1'b0, 5'd0, 12'h0, 32'd0, 32'd0, 32'd0, 32'd0, 4'd0);

    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_decode_execute_stage
